// File: rtl/pipeline_skid_stage_pkg.sv
// Shared CPU pipeline definitions: the occupancy encoding used by elastic stages.
package pipeline_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline stage with a 2-entry skid buffer. o_Ready and o_Valid come
// only from the state register, so i_Ready never reaches o_Ready combinationally.
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] INITIAL = '0
) (
  input  logic            i_Clk,
  input  logic            i_nRst,
  input  logic            i_Flush,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [SIZE-1:0] i_Data,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [SIZE-1:0] o_Data,
  output logic [1:0]      o_Count
);

  state_t          state_reg, state_next;
  logic [SIZE-1:0] main_reg, skid_reg;
  logic            in_fire, out_fire;
  logic            load_main_in, load_main_skid, load_skid;

  assign o_Valid  = (state_reg != ST_EMPTY);
  assign o_Ready  = (state_reg != ST_TWO);
  assign o_Count  = state_reg;
  assign o_Data   = main_reg;
  assign in_fire  = i_Valid & o_Ready;
  assign out_fire = o_Valid & i_Ready;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next   = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // The skid entry is older than anything upstream, so it moves up first.
        if (out_fire) begin
          state_next     = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_reg <= ST_EMPTY;
    end else if (i_Flush) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      main_reg <= INITIAL;
    end else if (i_Flush) begin
      main_reg <= INITIAL;
    end else if (load_main_in) begin
      main_reg <= i_Data;
    end else if (load_main_skid) begin
      main_reg <= skid_reg;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      skid_reg <= INITIAL;
    end else if (i_Flush) begin
      skid_reg <= INITIAL;
    end else if (load_skid) begin
      skid_reg <= i_Data;
    end
  end

`ifndef SYNTHESIS
  count_range: assert property (@(posedge i_Clk) disable iff (!i_nRst)
    o_Count != 2'd3);
  count_ready: assert property (@(posedge i_Clk) disable iff (!i_Nrst_unused_guard())
    (o_Count == 2'd2) == !o_Ready);
  stall_stable: assert property (@(posedge i_Clk) disable iff (!i_nRst)
    (o_Valid && !i_Ready && !i_Flush) |=> (o_Valid && $stable(o_Data)));

  function automatic logic i_Nrst_unused_guard();
    return i_nRst;
  endfunction
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Scoreboard bench: the driver queues every accepted word, a negedge monitor
// pops and compares on each downstream transfer and checks occupancy.
module tb_pipeline_skid_stage;

  logic       i_Clk = 1'b0;
  logic       i_nRst, i_Flush, i_Valid, i_Ready;
  logic [7:0] i_Data;
  logic       o_Ready, o_Valid;
  logic [7:0] o_Data;
  logic [1:0] o_Count;

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  logic [7:0] q[$];
  logic       acc_pend = 1'b0;
  logic       flush_pend = 1'b0;
  logic [7:0] d_pend = 8'h00;

  pipeline_skid_stage #(.SIZE(8), .INITIAL(8'hAA)) dut (
    .i_Clk(i_Clk), .i_nRst(i_nRst), .i_Flush(i_Flush),
    .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Data(i_Data),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data), .o_Count(o_Count)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard push: the words the driver decided were accepted at this edge.
  always @(posedge i_Clk) begin
    if (i_nRst) begin
      if (flush_pend) q.delete();
      else if (acc_pend) q.push_back(d_pend);
    end
  end

  // Monitor: occupancy against the scoreboard, then in-order data on out_fire.
  always @(negedge i_Clk) begin
    logic [7:0] exp_d;
    check("count", {30'd0, o_Count}, q.size());
    check("ready", {31'd0, o_Ready}, {31'd0, q.size() != 2});
    check("valid", {31'd0, o_Valid}, {31'd0, q.size() != 0});
    if (o_Valid && i_Ready && i_nRst && q.size() != 0) begin
      exp_d = q.pop_front();
      check("data", {24'd0, o_Data}, {24'd0, exp_d});
      $display("out %02h (expected %02h) t=%0t", o_Data, exp_d, $time);
      delivered++;
    end
  end

  // Called #1 after a rising edge; applies inputs for one cycle.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
    i_Valid = v; i_Data = d; i_Ready = r; i_Flush = f;
    flush_pend = f;
    acc_pend = v && o_Ready && !f;
    d_pend = d;
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    int base;
    void'($urandom(32'd1234));
    i_nRst = 1'b0; i_Flush = 1'b0; i_Valid = 1'b0; i_Ready = 1'b0; i_Data = 8'h00;
    repeat (2) @(posedge i_Clk);
    #1;
    check("rst_valid", {31'd0, o_Valid}, 32'd0);
    check("rst_ready", {31'd0, o_Ready}, 32'd1);
    check("rst_count", {30'd0, o_Count}, 32'd0);
    check("rst_data", {24'd0, o_Data}, 32'hAA);
    i_nRst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_data", {24'd0, o_Data}, 32'hAA);

    // Full-rate stream
    base = delivered;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, k[7:0], 1'b1, 1'b0);
      check("stream_data", {24'd0, o_Data}, k);
      check("stream_count", {30'd0, o_Count}, 32'd1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_delivered", delivered - base, 32'd8);

    // Back-pressure into the skid slot
    base = delivered;
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    check("full_count", {30'd0, o_Count}, 32'd2);
    check("full_ready", {31'd0, o_Ready}, 32'd0);
    check("full_data", {24'd0, o_Data}, 32'h10);
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    check("reject_count", {30'd0, o_Count}, 32'd2);
    check("hold_data", {24'd0, o_Data}, 32'h10);
    i_Ready = 1'b1;
    #1;
    check("ready_registered", {31'd0, o_Ready}, 32'd0);
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    check("drain_data0", {24'd0, o_Data}, 32'h11);
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    check("drain_data1", {24'd0, o_Data}, 32'h12);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_delivered", delivered - base, 32'd3);

    // Flush while full, with a word offered in the same cycle
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    check("flush_valid", {31'd0, o_Valid}, 32'd0);
    check("flush_count", {30'd0, o_Count}, 32'd0);
    check("flush_data", {24'd0, o_Data}, 32'hAA);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle while holding data
    cycle(1'b1, 8'h20, 1'b1, 1'b0);
    cycle(1'b1, 8'h21, 1'b1, 1'b0);
    #2;
    i_nRst = 1'b0;
    acc_pend = 1'b0; flush_pend = 1'b0;
    q.delete();
    #1;
    check("arst_valid", {31'd0, o_Valid}, 32'd0);
    check("arst_data", {24'd0, o_Data}, 32'hAA);
    check("arst_count", {30'd0, o_Count}, 32'd0);
    @(posedge i_Clk);
    #1;
    i_nRst = 1'b1;
    base = delivered;
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'h30 + k[7:0], 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("resume_delivered", delivered - base, 32'd4);

    // Random handshakes with occasional flush
    for (int n = 0; n < 10000; n++) begin
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0);
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
